hamming_enc_seq: RTL

Multi-cycle sequencer that sits directly upstream of the ALU and drives it to build a (16,11) SECDED Hamming codeword from an 11-bit data word. It steps through seven ALU opcodes, one per cycle, merging each ALU result into two working bytes (LSW, MSW), then presents the encoded pair with a one-cycle `done` pulse. This replaces the software instruction sequence for the encode program with a single start/done macro operation.

---
 rtl/alu_pkg.sv | 33 +++
 rtl/alu.sv | 37 +++
 rtl/hamming_enc_seq.sv | 104 ++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU opcodes and the encode-sequencer state type.
package alu_pkg;

    localparam logic [3:0] OP_ADD   = 4'h0;
    localparam logic [3:0] OP_SUB   = 4'h1;
    localparam logic [3:0] OP_AND   = 4'h2;
    localparam logic [3:0] OP_OR    = 4'h3;
    localparam logic [3:0] OP_XOR   = 4'h4;
    localparam logic [3:0] OP_NOT   = 4'h5;
    localparam logic [3:0] OP_SHL   = 4'h6;
    localparam logic [3:0] OP_SHR   = 4'h7;
    localparam logic [3:0] OP_P0    = 4'h8;
    localparam logic [3:0] OP_P1    = 4'h9;
    localparam logic [3:0] OP_P2    = 4'hA;
    localparam logic [3:0] OP_P4    = 4'hB;
    localparam logic [3:0] OP_P8    = 4'hC;
    localparam logic [3:0] OP_PKL   = 4'hD;
    localparam logic [3:0] OP_PKH   = 4'hE;
    localparam logic [3:0] OP_UNPKL = 4'hF;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_PKL,
        ST_PKH,
        ST_P1,
        ST_P2,
        ST_P4,
        ST_P8,
        ST_P0,
        ST_DONE
    } enc_state_t;

endpackage

// File: rtl/alu.sv
// 8-bit combinational ALU with Hamming (16,11) pack/parity helper ops.
// Codeword layout: LSW = positions 7..0, MSW = positions 15..8.
// Operand A holds d7..d0, operand B holds d10..d8 in bits 2..0.
module alu
    import alu_pkg::*;
(
    input  logic [3:0] op,
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] rslt
);

    // Result select; parity ops set only their own codeword bit.
    always_comb begin
        rslt = '0;
        case (op)
            OP_ADD:   rslt = a + b;
            OP_SUB:   rslt = a - b;
            OP_AND:   rslt = a & b;
            OP_OR:    rslt = a | b;
            OP_XOR:   rslt = a ^ b;
            OP_NOT:   rslt = ~a;
            OP_SHL:   rslt = {a[6:0], 1'b0};
            OP_SHR:   rslt = {1'b0, a[7:1]};
            OP_P0:    rslt = {7'b0, (^a) ^ (^b)};
            OP_P1:    rslt = {6'b0, (^(a & 8'h5B)) ^ (^(b & 8'h05)), 1'b0};
            OP_P2:    rslt = {5'b0, (^(a & 8'h6D)) ^ (^(b & 8'h06)), 2'b0};
            OP_P4:    rslt = {3'b0, (^(a & 8'h8E)) ^ (^(b & 8'h07)), 4'b0};
            OP_P8:    rslt = {7'b0, (^(a & 8'hF0)) ^ (^(b & 8'h07))};
            OP_PKL:   rslt = {a[3:1], 1'b0, a[0], 3'b0};
            OP_PKH:   rslt = {b[2:0], a[7:4], 1'b0};
            OP_UNPKL: rslt = {b[4:1], a[7:5], a[3]};
            default:  rslt = '0;
        endcase
    end

endmodule

// File: rtl/hamming_enc_seq.sv
// Drives the ALU through the (16,11) SECDED encode program, one op per cycle,
// accumulating the codeword in two working bytes.
module hamming_enc_seq
    import alu_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        start,
    input  logic [10:0] data_in,
    output logic        busy,
    output logic        done,
    output logic [7:0]  enc_lsw,
    output logic [7:0]  enc_msw,
    output logic [3:0]  alu_op,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    input  logic [7:0]  alu_rslt
);

    enc_state_t state, state_nxt;
    logic [7:0] dl, dh;
    logic [7:0] lsw, msw;

    // State register and working-byte capture of the ALU result.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state <= ST_IDLE;
            dl    <= '0;
            dh    <= '0;
            lsw   <= '0;
            msw   <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        dl  <= data_in[7:0];
                        dh  <= {5'b0, data_in[10:8]};
                        lsw <= '0;
                        msw <= '0;
                    end
                end
                ST_PKL: lsw <= alu_rslt;
                ST_PKH: msw <= alu_rslt;
                ST_P1,
                ST_P2,
                ST_P4:  lsw <= lsw | alu_rslt;
                ST_P8:  msw <= msw | alu_rslt;
                ST_P0:  lsw <= lsw | {7'b0, alu_rslt[0]};
                default: ;
            endcase
        end
    end

    // Next state and ALU command/operands per step; overall parity runs last.
    always_comb begin
        state_nxt = state;
        alu_op    = OP_ADD;
        alu_a     = '0;
        alu_b     = '0;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_PKL;
            ST_PKL: begin
                alu_op = OP_PKL; alu_a = dl;
                state_nxt = ST_PKH;
            end
            ST_PKH: begin
                alu_op = OP_PKH; alu_a = dl; alu_b = dh;
                state_nxt = ST_P1;
            end
            ST_P1: begin
                alu_op = OP_P1; alu_a = dl; alu_b = dh;
                state_nxt = ST_P2;
            end
            ST_P2: begin
                alu_op = OP_P2; alu_a = dl; alu_b = dh;
                state_nxt = ST_P4;
            end
            ST_P4: begin
                alu_op = OP_P4; alu_a = dl; alu_b = dh;
                state_nxt = ST_P8;
            end
            ST_P8: begin
                alu_op = OP_P8; alu_a = dl; alu_b = dh;
                state_nxt = ST_P0;
            end
            ST_P0: begin
                alu_op = OP_P0; alu_a = lsw; alu_b = msw;
                state_nxt = ST_DONE;
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Status and result outputs.
    always_comb begin
        busy    = (state != ST_IDLE);
        done    = (state == ST_DONE);
        enc_lsw = lsw;
        enc_msw = msw;
    end

endmodule
